// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - control/data bundle between the multiplier control FSM and the shift sequencer
//
// Purpose : groups the shift sequencer's request and result signals.
// Signals : load, load_data  - parallel load request and value
//           start, amount    - begin a sequence of 'amount' single-bit shifts
//           mode             - 00 arith right, 01 logical right, 10 logical left, 11 rotate right
//           enable           - while busy, 1 = shift this cycle, 0 = hold
//           out              - register contents
//           busy, done       - sequence in progress / one-cycle completion pulse
//           shifted_out      - bit most recently shifted out
// Modports: master (control FSM side), slave (shift sequencer side)

interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
);
   logic                    load;
   logic signed [WIDTH-1:0] load_data;
   logic                    start;
   logic [CNT_W-1:0]        amount;
   logic [1:0]              mode;
   logic                    enable;
   logic signed [WIDTH-1:0] out;
   logic                    busy;
   logic                    done;
   logic                    shifted_out;

   modport master (
      output load, load_data, start, amount, mode, enable,
      input  out, busy, done, shifted_out
   );

   modport slave (
      input  load, load_data, start, amount, mode, enable,
      output out, busy, done, shifted_out
   );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-bit shift register executing N single-bit shifts under start/busy/done
//
// Purpose : performs a requested number of one-bit shifts, one per enabled clock, in
//           arithmetic-right, logical-right, logical-left or rotate-right mode, keeping the
//           last bit shifted out as a carry/guard bit.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous, active-high
//           bus   - shift_sequencer_if.slave (load/start/amount/mode/enable in,
//                   out/busy/done/shifted_out out)

module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   shift_sequencer_if.slave  bus
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                  r_state,   w_state_nxt;
   logic [CNT_W-1:0]        r_cnt,     w_cnt_nxt;
   logic [1:0]              r_mode,    w_mode_nxt;
   logic signed [WIDTH-1:0] r_out,     w_out_nxt;
   logic                    r_done,    w_done_nxt;
   logic                    r_sh,      w_sh_nxt;

   logic signed [WIDTH-1:0] w_shift_val;
   logic                    w_shift_bit;

   // One-step shift of the current contents using the mode latched at start.
   always_comb begin
      w_shift_val = r_out;
      w_shift_bit = r_out[0];
      case (r_mode)
         2'b00: w_shift_val = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
         2'b01: w_shift_val = {1'b0, r_out[WIDTH-1:1]};
         2'b10: begin
            w_shift_val = {r_out[WIDTH-2:0], 1'b0};
            w_shift_bit = r_out[WIDTH-1];
         end
         default: w_shift_val = {r_out[0], r_out[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      w_out_nxt   = r_out;
      w_sh_nxt    = r_sh;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Load wins over a simultaneous start; that start is dropped.
            if (bus.load) begin
               w_out_nxt = bus.load_data;
            end else if (bus.start) begin
               w_sh_nxt = 1'b0;
               if (bus.amount == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_mode_nxt  = bus.mode;
                  w_cnt_nxt   = bus.amount;
                  w_state_nxt = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            if (bus.enable) begin
               w_out_nxt = w_shift_val;
               w_sh_nxt  = w_shift_bit;
               w_cnt_nxt = r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mode  <= 2'b00;
         r_out   <= '0;
         r_done  <= 1'b0;
         r_sh    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
         r_out   <= w_out_nxt;
         r_done  <= w_done_nxt;
         r_sh    <= w_sh_nxt;
      end
   end

   assign bus.out         = r_out;
   assign bus.busy        = (r_state == S_SHIFT);
   assign bus.done        = r_done;
   assign bus.shifted_out = r_sh;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard testbench for shift_sequencer

module tb_shift_sequencer;

   localparam int WIDTH = 16;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef struct {
      logic [15:0] out;
      logic        sh;
      int          cycles;
   } exp_t;

   logic clk;
   logic reset;

   shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks;
   int          n_errors;
   int          busy_cnt;
   int          done_cnt;
   exp_t        sb[$];
   logic [15:0] mv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour: returns {last shifted-out bit, final value}.
   function automatic logic [16:0] model(input logic [15:0] v, input logic [1:0] m, input int n);
      logic [15:0] x;
      logic        s;
      x = v;
      s = 1'b0;
      for (int i = 0; i < n; i++) begin
         case (m)
            2'b00: begin s = x[0];  x = {x[15], x[15:1]}; end
            2'b01: begin s = x[0];  x = {1'b0, x[15:1]}; end
            2'b10: begin s = x[15]; x = {x[14:0], 1'b0}; end
            default: begin s = x[0]; x = {x[0], x[15:1]}; end
         endcase
      end
      return {s, x};
   endfunction

   // Completion monitor: every done pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         busy_cnt = 0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 16'd1, 16'd0);
            end else begin
               e = sb.pop_front();
               check("result_out", bus.out, e.out);
               check("result_shifted_out", 16'(bus.shifted_out), 16'(e.sh));
               check("busy_cycles", 16'(busy_cnt), 16'(e.cycles));
            end
            busy_cnt = 0;
            done_cnt++;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load_val(input logic [15:0] v);
      bus.load      = 1'b1;
      bus.load_data = v;
      tick();
      bus.load      = 1'b0;
      mv            = v;
      tick();
      check("load_out", bus.out, v);
   endtask

   // Runs one sequence; optionally drops enable for stall_len cycles starting at
   // stall_at while pulsing start and load, which must be ignored.
   task automatic run(input int n, input logic [1:0] m, input int stall_at, input int stall_len);
      exp_t        e;
      logic [16:0] r;
      logic [16:0] first;
      int          base;
      int          cyc;
      r        = model(mv, m, n);
      first    = model(mv, m, 1);
      e.out    = r[15:0];
      e.sh     = r[16];
      e.cycles = n + stall_len;
      sb.push_back(e);
      base       = done_cnt;
      bus.start  = 1'b1;
      bus.amount = CNT_W'(n);
      bus.mode   = m;
      tick();
      bus.start  = 1'b0;
      bus.mode   = ~m;
      check("busy_after_start", 16'(bus.busy), (n >= 1) ? 16'd1 : 16'd0);
      cyc = 0;
      while (done_cnt == base && cyc < 300) begin
         if (cyc == 1 && n >= 1) check("first_shift", bus.out, first[15:0]);
         if (stall_len > 0 && cyc == stall_at) begin
            bus.enable    = 1'b0;
            bus.start     = 1'b1;
            bus.load      = 1'b1;
            bus.load_data = 16'hDEAD;
         end
         if (stall_len > 0 && cyc == stall_at + stall_len) begin
            bus.enable = 1'b1;
            bus.start  = 1'b0;
            bus.load   = 1'b0;
         end
         tick();
         cyc++;
      end
      if (done_cnt == base) check("done_timeout", 16'd0, 16'd1);
      mv = e.out;
      tick();
      check("done_single_pulse", 16'(bus.done), 16'd0);
      check("idle_after_done", 16'(bus.busy), 16'd0);
   endtask

   initial begin
      int base;
      n_checks      = 0;
      n_errors      = 0;
      busy_cnt      = 0;
      done_cnt      = 0;
      mv            = 16'h0000;
      reset         = 1'b1;
      bus.load      = 1'b0;
      bus.load_data = '0;
      bus.start     = 1'b0;
      bus.amount    = '0;
      bus.mode      = 2'b00;
      bus.enable    = 1'b1;
      tick();
      tick();
      check("reset_out", bus.out, 16'h0000);
      check("reset_busy", 16'(bus.busy), 16'd0);
      check("reset_done", 16'(bus.done), 16'd0);
      check("reset_shifted_out", 16'(bus.shifted_out), 16'd0);
      reset = 1'b0;
      tick();

      load_val(16'h8000);
      run(3, 2'b00, 0, 0);
      load_val(16'h8001);
      run(1, 2'b01, 0, 0);
      load_val(16'h4001);
      run(2, 2'b10, 0, 0);
      load_val(16'h0003);
      run(17, 2'b11, 0, 0);
      load_val(16'h0F00);
      run(4, 2'b00, 1, 2);
      load_val(16'hA5C3);
      run(20, 2'b00, 0, 0);
      run(0, 2'b01, 0, 0);
      load_val(16'h1234);
      run(31, 2'b10, 0, 0);

      // Back-to-back: a new start issued in the done cycle is accepted without a gap.
      load_val(16'h00F0);
      sb.push_back('{out: 16'h0078, sh: 1'b0, cycles: 1});
      sb.push_back('{out: 16'h003C, sh: 1'b0, cycles: 1});
      base       = done_cnt;
      bus.start  = 1'b1;
      bus.amount = CNT_W'(1);
      bus.mode   = 2'b01;
      tick();
      bus.start = 1'b0;
      tick();
      check("b2b_first_done", 16'(done_cnt - base), 16'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      check("b2b_second_done", 16'(done_cnt - base), 16'd2);
      mv = 16'h003C;

      // Reset during the second cycle of a five-shift sequence aborts without done.
      load_val(16'h00FF);
      base       = done_cnt;
      bus.start  = 1'b1;
      bus.amount = CNT_W'(5);
      bus.mode   = 2'b00;
      tick();
      bus.start = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("abort_out", bus.out, 16'h0000);
      check("abort_busy", 16'(bus.busy), 16'd0);
      check("abort_done", 16'(bus.done), 16'd0);
      check("abort_shifted_out", 16'(bus.shifted_out), 16'd0);
      sb.delete();
      mv = 16'h0000;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("abort_no_done", 16'(done_cnt - base), 16'd0);
      run(0, 2'b00, 0, 0);
      load_val(16'h5A5A);
      run(0, 2'b11, 0, 0);
      check("sb_drained", 16'(sb.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
